// File: rtl/load_store_unit.sv
// load_store_unit: initiator for a 512-byte big-endian data memory. It range-checks requests, splits misaligned ones into byte transfers and extends load data.
// Build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests return an error instead of being split.
module load_store_unit #(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 512
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Req_Valid,
   output logic              Req_Ready,
   input  logic              Req_Write,
   input  logic [1:0]        Req_Size,
   input  logic              Req_Unsigned,
   input  logic [ADDR_W-1:0] Req_Addr,
   input  logic [31:0]       Req_W_Data,
   output logic              Resp_Valid,
   input  logic              Resp_Ready,
   output logic [31:0]       Resp_Data,
   output logic              Resp_Err,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [31:0]       Mem_W_Data,
   input  logic [31:0]       Mem_R_Data,
   output logic              Read_M,
   output logic              Write_M,
   output logic              OneByte,
   output logic              HalfWord,
   output logic              OneWord
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_SPLIT  = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   localparam int AW1 = ADDR_W + 1;
   localparam logic [ADDR_W:0] LAST_BYTE = AW1'(MEM_BYTES - 1);

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit MISALIGN_TRAP = 1'b1;
`else
   localparam bit MISALIGN_TRAP = 1'b0;
`endif

   logic [1:0]        state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic              write_reg;
   logic              unsigned_reg;
   logic [1:0]        size_reg;
   logic [1:0]        idx_reg;
   logic [23:0]       acc_reg;
   logic              resp_valid_reg;
   logic              resp_err_reg;
   logic [31:0]       resp_data_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [31:0]       mem_w_data_reg;
   logic              read_m_reg;
   logic              write_m_reg;
   logic              one_byte_reg;
   logic              half_word_reg;
   logic              one_word_reg;

   logic [ADDR_W:0]   req_last;
   logic              req_misaligned;
   logic              req_err;
   logic [1:0]        split_last;
   logic [1:0]        idx_next;
   logic [31:0]       split_acc;

   // Last byte touched is computed one bit wider so an access near the top of the address space cannot wrap.
   always_comb begin
      case (Req_Size)
         SZ_HALF: req_last = {1'b0, Req_Addr} + AW1'(1);
         SZ_WORD: req_last = {1'b0, Req_Addr} + AW1'(3);
         default: req_last = {1'b0, Req_Addr};
      endcase
      req_misaligned = ((Req_Size == SZ_HALF) && Req_Addr[0]) ||
                       ((Req_Size == SZ_WORD) && (Req_Addr[1:0] != 2'b00));
      req_err = (Req_Size == SZ_ILL) || (req_last > LAST_BYTE) ||
                (MISALIGN_TRAP && req_misaligned);
   end

   assign split_last = (size_reg == SZ_WORD) ? 2'd3 : 2'd1;
   assign idx_next   = idx_reg + 2'd1;
   assign split_acc  = {acc_reg, Mem_R_Data[7:0]};

   // Byte idx of a split store; idx 0 is the most-significant byte of the sized datum.
   function automatic logic [7:0] split_byte(input logic [31:0] data, input logic [1:0] size,
                                             input logic [1:0] idx);
      logic [1:0] last;
      logic [4:0] sh;
      last = (size == SZ_WORD) ? 2'd3 : 2'd1;
      sh   = {last - idx, 3'b000};
      return 8'(data >> sh);
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] data, input logic [1:0] size,
                                          input logic uns);
      logic [31:0] res;
      case (size)
         SZ_BYTE: res = {{24{data[7] & ~uns}}, data[7:0]};
         SZ_HALF: res = {{16{data[15] & ~uns}}, data[15:0]};
         default: res = data;
      endcase
      return res;
   endfunction

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg      <= ST_IDLE;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         write_reg      <= 1'b0;
         unsigned_reg   <= 1'b0;
         size_reg       <= SZ_BYTE;
         idx_reg        <= 2'd0;
         acc_reg        <= '0;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         resp_data_reg  <= '0;
         mem_addr_reg   <= '0;
         mem_w_data_reg <= '0;
         read_m_reg     <= 1'b0;
         write_m_reg    <= 1'b0;
         one_byte_reg   <= 1'b0;
         half_word_reg  <= 1'b0;
         one_word_reg   <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses unless a branch below re-arms them.
         read_m_reg    <= 1'b0;
         write_m_reg   <= 1'b0;
         one_byte_reg  <= 1'b0;
         half_word_reg <= 1'b0;
         one_word_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (Req_Valid) begin
                  addr_reg     <= Req_Addr;
                  wdata_reg    <= Req_W_Data;
                  write_reg    <= Req_Write;
                  unsigned_reg <= Req_Unsigned;
                  size_reg     <= Req_Size;
                  idx_reg      <= 2'd0;
                  acc_reg      <= '0;
                  if (req_err) begin
                     state_reg      <= ST_RESP;
                     resp_valid_reg <= 1'b1;
                     resp_err_reg   <= 1'b1;
                     resp_data_reg  <= '0;
                  end else if (req_misaligned) begin
                     state_reg      <= ST_SPLIT;
                     mem_addr_reg   <= Req_Addr;
                     read_m_reg     <= ~Req_Write;
                     write_m_reg    <= Req_Write;
                     one_byte_reg   <= 1'b1;
                     mem_w_data_reg <= Req_Write ?
                                       {24'h0, split_byte(Req_W_Data, Req_Size, 2'd0)} : 32'h0;
                  end else begin
                     state_reg      <= ST_ACCESS;
                     mem_addr_reg   <= Req_Addr;
                     read_m_reg     <= ~Req_Write;
                     write_m_reg    <= Req_Write;
                     one_byte_reg   <= (Req_Size == SZ_BYTE);
                     half_word_reg  <= (Req_Size == SZ_HALF);
                     one_word_reg   <= (Req_Size == SZ_WORD);
                     mem_w_data_reg <= Req_Write ? Req_W_Data : 32'h0;
                  end
               end
            end
            ST_ACCESS: begin
               state_reg      <= ST_RESP;
               resp_valid_reg <= 1'b1;
               resp_err_reg   <= 1'b0;
               resp_data_reg  <= write_reg ? 32'h0 : extend(Mem_R_Data, size_reg, unsigned_reg);
            end
            ST_SPLIT: begin
               if (idx_reg == split_last) begin
                  state_reg      <= ST_RESP;
                  resp_valid_reg <= 1'b1;
                  resp_err_reg   <= 1'b0;
                  resp_data_reg  <= write_reg ? 32'h0 : extend(split_acc, size_reg, unsigned_reg);
               end else begin
                  idx_reg        <= idx_next;
                  acc_reg        <= split_acc[23:0];
                  mem_addr_reg   <= addr_reg + ADDR_W'(idx_next);
                  read_m_reg     <= ~write_reg;
                  write_m_reg    <= write_reg;
                  one_byte_reg   <= 1'b1;
                  mem_w_data_reg <= write_reg ?
                                    {24'h0, split_byte(wdata_reg, size_reg, idx_next)} : 32'h0;
               end
            end
            default: begin
               if (Resp_Ready) begin
                  state_reg      <= ST_IDLE;
                  resp_valid_reg <= 1'b0;
                  resp_err_reg   <= 1'b0;
                  resp_data_reg  <= '0;
               end
            end
         endcase
      end
   end

   assign Req_Ready  = (state_reg == ST_IDLE);
   assign Resp_Valid = resp_valid_reg;
   assign Resp_Data  = resp_data_reg;
   assign Resp_Err   = resp_err_reg;
   assign Mem_Addr   = mem_addr_reg;
   assign Mem_W_Data = mem_w_data_reg;
   assign Read_M     = read_m_reg;
   assign Write_M    = write_m_reg;
   assign OneByte    = one_byte_reg;
   assign HalfWord   = half_word_reg;
   assign OneWord    = one_word_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 512-byte big-endian memory device plus a byte-array reference model,
// directed cases followed by random requests. Honours LSU_MISALIGN_TRAP_EN for expected results.
module tb_load_store_unit;

   localparam int MEM_BYTES = 512;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Req_Valid;
   logic        Req_Ready;
   logic        Req_Write;
   logic [1:0]  Req_Size;
   logic        Req_Unsigned;
   logic [31:0] Req_Addr;
   logic [31:0] Req_W_Data;
   logic        Resp_Valid;
   logic        Resp_Ready;
   logic [31:0] Resp_Data;
   logic        Resp_Err;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_W_Data;
   logic [31:0] Mem_R_Data;
   logic        Read_M, Write_M, OneByte, HalfWord, OneWord;

   always #5 Clk = ~Clk;

   load_store_unit #(.ADDR_W(32), .MEM_BYTES(MEM_BYTES)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
      .Req_Size(Req_Size), .Req_Unsigned(Req_Unsigned), .Req_Addr(Req_Addr),
      .Req_W_Data(Req_W_Data),
      .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Data(Resp_Data),
      .Resp_Err(Resp_Err),
      .Mem_Addr(Mem_Addr), .Mem_W_Data(Mem_W_Data), .Mem_R_Data(Mem_R_Data),
      .Read_M(Read_M), .Write_M(Write_M), .OneByte(OneByte), .HalfWord(HalfWord),
      .OneWord(OneWord)
   );

   logic [7:0]  dmem     [MEM_BYTES];
   logic [7:0]  init_img [MEM_BYTES];
   logic [7:0]  ref_mem  [MEM_BYTES];
   logic        init_req;
   int          mem_n;
   int          checks   = 0;
   int          failures = 0;
   int          txn      = 0;
   logic [31:0] seen_addr[$];
   logic [4:0]  seen_kind[$];

   // Memory device: combinational big-endian read, write on the rising edge.
   function automatic logic [7:0] dmem_rd(input logic [31:0] a);
      return (a < 32'(MEM_BYTES)) ? dmem[a[8:0]] : 8'h00;
   endfunction

   always_comb begin
      mem_n      = OneWord ? 4 : (HalfWord ? 2 : 1);
      Mem_R_Data = 32'h0;
      if (Read_M) begin
         if (OneWord)
            Mem_R_Data = {dmem_rd(Mem_Addr), dmem_rd(Mem_Addr + 1), dmem_rd(Mem_Addr + 2),
                          dmem_rd(Mem_Addr + 3)};
         else if (HalfWord)
            Mem_R_Data = {16'h0, dmem_rd(Mem_Addr), dmem_rd(Mem_Addr + 1)};
         else if (OneByte)
            Mem_R_Data = {24'h0, dmem_rd(Mem_Addr)};
      end
   end

   always @(posedge Clk) begin
      if (init_req) begin
         for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= init_img[i];
      end else if (Write_M) begin
         for (int i = 0; i < 4; i++) begin
            if (i < mem_n && (Mem_Addr + 32'(i)) < 32'(MEM_BYTES))
               dmem[9'(Mem_Addr + 32'(i))] <= 8'(Mem_W_Data >> (8 * (mem_n - 1 - i)));
         end
      end
   end

   // Log every strobe cycle: address and {Write_M, Read_M, OneWord, HalfWord, OneByte}.
   always @(negedge Clk) begin
      if (Read_M || Write_M || OneByte || HalfWord || OneWord) begin
         seen_addr.push_back(Mem_Addr);
         seen_kind.push_back({Write_M, Read_M, OneWord, HalfWord, OneByte});
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model straight from the access rules: sizes, range, alignment, big-endian bytes.
   task automatic model(input bit w, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                        output bit err, output bit split, output int n, output logic [31:0] data);
      logic [63:0] last;
      longint      v;
      n     = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
      last  = {32'h0, addr} + 64'(n - 1);
      split = (addr % 32'(n)) != 0;
      err   = (sz == 2'd3) || (last > 64'(MEM_BYTES - 1));
`ifdef LSU_MISALIGN_TRAP_EN
      err = err || split;
`endif
      data = 32'h0;
      if (!err && !w) begin
         v = 0;
         for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(addr) + i]);
         if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
         data = 32'(v);
      end
   endtask

   task automatic do_req(input bit w, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input bit has_spec,
                         input logic [31:0] spec_data);
      bit          err, split;
      int          n, lat, exp_lat, exp_cnt;
      logic [31:0] exp_data, held_data;
      logic        held_err;
      logic [4:0]  exp_kind;
      model(w, sz, uns, addr, err, split, n, exp_data);
      exp_lat  = err ? 1 : (split ? 1 + n : 2);
      exp_cnt  = err ? 0 : (split ? n : 1);
      exp_kind = split ? {w, ~w, 3'b001} : {w, ~w, sz == 2'd2, sz == 2'd1, sz == 2'd0};

      @(posedge Clk);
      #1;
      seen_addr.delete();
      seen_kind.delete();
      check_eq("req_ready_idle", Req_Ready, 1'b1);
      Req_Valid = 1'b1; Req_Write = w; Req_Size = sz; Req_Unsigned = uns;
      Req_Addr = addr; Req_W_Data = wdata;
      @(posedge Clk);
      #1;
      // Junk request held on the bus while busy must be ignored.
      Req_Write = 1'($urandom); Req_Size = 2'($urandom); Req_Addr = $urandom_range(0, 520);
      Req_W_Data = $urandom;

      lat = 0;
      do begin
         @(negedge Clk);
         lat++;
      end while (!Resp_Valid && lat < 20);
      if (!Resp_Valid) begin
         check_eq("resp_timeout", 1'b0, 1'b1);
         Req_Valid = 1'b0;
         Rst_n = 1'b0;
         @(posedge Clk);
         #1 Rst_n = 1'b1;
         return;
      end
      check_eq("latency", 64'(lat), 64'(exp_lat));
      check_eq("resp_err", Resp_Err, err);
      check_eq("resp_data", Resp_Data, exp_data);
      if (has_spec) check_eq("spec_data", Resp_Data, spec_data);
      check_eq("strobe_count", 64'(seen_addr.size()), 64'(exp_cnt));
      for (int i = 0; i < seen_addr.size() && i < exp_cnt; i++) begin
         check_eq("strobe_addr", seen_addr[i], addr + 32'(i));
         check_eq("strobe_kind", seen_kind[i], exp_kind);
      end

      held_data = Resp_Data;
      held_err  = Resp_Err;
      for (int h = 0; h < hold; h++) begin
         @(negedge Clk);
         check_eq("hold_valid", Resp_Valid, 1'b1);
         check_eq("hold_data", {held_err, held_data}, {Resp_Err, Resp_Data});
         check_eq("hold_not_ready", Req_Ready, 1'b0);
      end
      Req_Valid  = 1'b0;
      Resp_Ready = 1'b1;
      @(posedge Clk);
      #1 Resp_Ready = 1'b0;
      @(negedge Clk);
      check_eq("resp_dropped", Resp_Valid, 1'b0);
      check_eq("ready_back", Req_Ready, 1'b1);

      if (w && !err)
         for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * (n - 1 - i)));
      txn++;
      $display("txn %0d w=%0b sz=%0d uns=%0b addr=%h data=%h err=%0b lat=%0d", txn, w, sz, uns,
               addr, Resp_Data, err, lat);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          r, mism;
      Rst_n = 1'b0; init_req = 1'b1; Resp_Ready = 1'b0;
      Req_Valid = 1'b0; Req_Write = 1'b0; Req_Size = 2'd0; Req_Unsigned = 1'b0;
      Req_Addr = 32'h0; Req_W_Data = 32'h0;
      for (int i = 0; i < MEM_BYTES; i++) init_img[i] = 8'($urandom);
      init_img[0] = 8'h12; init_img[1] = 8'h34; init_img[2] = 8'h56;
      init_img[3] = 8'h78; init_img[4] = 8'h9A; init_img[5] = 8'hBC;
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_img[i];

      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check_eq("rst_req_ready", Req_Ready, 1'b1);
      check_eq("rst_resp", {Resp_Valid, Resp_Err, Resp_Data}, 34'h0);
      check_eq("rst_mem_addr", Mem_Addr, 32'h0);
      check_eq("rst_mem_wdata", Mem_W_Data, 32'h0);
      check_eq("rst_strobes", {Read_M, Write_M, OneByte, HalfWord, OneWord}, 5'h0);
      @(posedge Clk);
      #1 init_req = 1'b0; Rst_n = 1'b1;

      do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 0, 1'b1, 32'h12345678);
      do_req(1'b0, 2'd0, 1'b0, 32'd4, 32'h0, 1, 1'b1, 32'hFFFFFF9A);
      do_req(1'b0, 2'd0, 1'b1, 32'd4, 32'h0, 0, 1'b1, 32'h0000009A);
      do_req(1'b0, 2'd1, 1'b0, 32'd4, 32'h0, 0, 1'b1, 32'hFFFF9ABC);
`ifdef LSU_MISALIGN_TRAP_EN
      do_req(1'b0, 2'd2, 1'b0, 32'd1, 32'h0, 0, 1'b1, 32'h00000000);
`else
      do_req(1'b0, 2'd2, 1'b0, 32'd1, 32'h0, 0, 1'b1, 32'h3456789A);
`endif
      do_req(1'b1, 2'd1, 1'b0, 32'd510, 32'h0000BEEF, 5, 1'b1, 32'h0);
      check_eq("mem510", dmem[510], 8'hBE);
      check_eq("mem511", dmem[511], 8'hEF);
      do_req(1'b1, 2'd2, 1'b0, 32'd510, 32'hDEADBEEF, 2, 1'b1, 32'h0);
      do_req(1'b0, 2'd1, 1'b1, 32'd510, 32'h0, 0, 1'b1, 32'h0000BEEF);
      do_req(1'b0, 2'd3, 1'b0, 32'd8, 32'h0, 0, 1'b1, 32'h0);
      do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 1'b1, 32'h0);

      for (int t = 0; t < 150; t++) begin
         r  = $urandom_range(0, 15);
         sz = (r == 0) ? 2'd3 : 2'(r % 3);
         r  = $urandom_range(0, 9);
         if (r < 8)       a = $urandom_range(0, MEM_BYTES - 1);
         else if (r == 8) a = $urandom_range(MEM_BYTES - 6, MEM_BYTES + 4);
         else             a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2), 1'b0, 32'h0);
      end

      // Reset in the middle of an access: strobes drop at once, completed byte writes persist.
      @(posedge Clk);
      #1;
      Req_Valid = 1'b1; Req_Write = 1'b1; Req_Unsigned = 1'b0; Req_W_Data = 32'hA1B2C3D4;
`ifdef LSU_MISALIGN_TRAP_EN
      Req_Size = 2'd2; Req_Addr = 32'd8;
      @(posedge Clk);
      #1 Req_Valid = 1'b0;
      @(negedge Clk);
`else
      Req_Size = 2'd2; Req_Addr = 32'd5;
      @(posedge Clk);
      #1 Req_Valid = 1'b0;
      repeat (3) @(negedge Clk);
      ref_mem[5] = 8'hA1;
      ref_mem[6] = 8'hB2;
`endif
      Rst_n = 1'b0;
      #1;
      check_eq("mid_rst_strobes", {Read_M, Write_M, OneByte, HalfWord, OneWord}, 5'h0);
      check_eq("mid_rst_ready", Req_Ready, 1'b1);
      check_eq("mid_rst_valid", Resp_Valid, 1'b0);
      @(posedge Clk);
      #1 Rst_n = 1'b1;
      @(negedge Clk);

      mism = 0;
      for (int i = 0; i < MEM_BYTES; i++) if (dmem[i] !== ref_mem[i]) mism++;
      check_eq("mem_final", 64'(mism), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
